// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Purpose  : I2C target. Detects START/STOP, matches a masked 7-bit address,
//            ACKs matched transfers, streams master-write bytes out on
//            m_axis_data and master-read bytes in from s_axis_data, and
//            stretches SCL whenever either stream cannot keep up.
// Ports    : clk, rst (sync, active-high), release_bus (abort pulse)
//            s_axis_data_*  : byte source for master reads (tlast ignored)
//            m_axis_data_*  : byte sink for master writes
//            scl_i/o/t, sda_i/o/t : open-drain pad interface (t=1 released)
//            busy, bus_address, bus_addressed, bus_active : status
//            enable, device_address, device_address_mask : address match
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       release_bus,
  input  logic [7:0] s_axis_data_tdata,
  input  logic       s_axis_data_tvalid,
  output logic       s_axis_data_tready,
  input  logic       s_axis_data_tlast,
  output logic [7:0] m_axis_data_tdata,
  output logic       m_axis_data_tvalid,
  input  logic       m_axis_data_tready,
  output logic       m_axis_data_tlast,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       busy,
  output logic [6:0] bus_address,
  output logic       bus_addressed,
  output logic       bus_active,
  input  logic       enable,
  input  logic [6:0] device_address,
  input  logic [6:0] device_address_mask
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDRESS = 3'd1;
  localparam logic [2:0] ST_AACK    = 3'd2;  // ACK of our address
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_WACK    = 3'd4;  // ACK of a written data byte
  localparam logic [2:0] ST_READ    = 3'd5;
  localparam logic [2:0] ST_RACK    = 3'd6;  // master ACK/NACK of a read byte

  // Sub-phase inside a state; meaning depends on the state (see FSM below).
  localparam logic [1:0] PH_A       = 2'd0;
  localparam logic [1:0] PH_B       = 2'd1;
  localparam logic [1:0] PH_STRETCH = 2'd2;

  // --------------------------------------------------------------------------
  // Synchroniser + filter: a filtered line only changes after FILTER_LEN
  // identical synchronised samples.
  // --------------------------------------------------------------------------
  logic [1:0]            scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic                  scl_f, sda_f, scl_prev, sda_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  // SCL must be high on both samples so an SDA change that coincides with
  // an SCL edge is never mistaken for a bus condition.
  assign start_det = sda_prev & ~sda_f & scl_f & scl_prev;
  assign stop_det  = ~sda_prev & sda_f & scl_f & scl_prev;

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  logic [2:0] state;
  logic [1:0] phase;
  logic [3:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic       rw;
  logic       pend;      // received byte not yet handed to m_axis
  logic [7:0] rx_byte;
  logic       m_free;
  logic       addr_hit;
  logic       unused_tlast;

  assign rx_byte      = {rx_shift[6:0], sda_f};
  assign m_free       = ~m_axis_data_tvalid | m_axis_data_tready;
  assign addr_hit     = enable &
                        (((rx_byte[7:1] ^ device_address) & device_address_mask) == 7'd0);
  assign unused_tlast = s_axis_data_tlast;

  // tready depends on tvalid so it is high for exactly the accepting cycle.
  assign s_axis_data_tready = ~rst & ~start_det & ~stop_det & ~release_bus &
                              (state == ST_READ) & (phase == PH_A) &
                              s_axis_data_tvalid;

  assign scl_o = scl_t;
  assign sda_o = sda_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      phase              <= PH_A;
      bit_cnt            <= 4'd0;
      rx_shift           <= 8'd0;
      tx_shift           <= 8'd0;
      rw                 <= 1'b0;
      pend               <= 1'b0;
      scl_t              <= 1'b1;
      sda_t              <= 1'b1;
      m_axis_data_tdata  <= 8'd0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tlast  <= 1'b0;
      busy               <= 1'b0;
      bus_address        <= 7'd0;
      bus_addressed      <= 1'b0;
      bus_active         <= 1'b0;
    end else begin
      if (m_axis_data_tvalid && m_axis_data_tready) m_axis_data_tvalid <= 1'b0;

      if (start_det || stop_det) begin
        // A byte still waiting downstream is the last one of this transfer.
        if (m_axis_data_tvalid && !m_axis_data_tready) m_axis_data_tlast <= 1'b1;
        state         <= start_det ? ST_ADDRESS : ST_IDLE;
        phase         <= PH_A;
        bit_cnt       <= 4'd0;
        pend          <= 1'b0;
        scl_t         <= 1'b1;
        sda_t         <= 1'b1;
        busy          <= 1'b0;
        bus_addressed <= 1'b0;
        bus_active    <= start_det;
      end else if (release_bus) begin
        state <= ST_IDLE;
        phase <= PH_A;
        pend  <= 1'b0;
        scl_t <= 1'b1;
        sda_t <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_ADDRESS: begin
            if (scl_rise) begin
              rx_shift <= rx_byte;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (addr_hit) begin
                  state       <= ST_AACK;
                  phase       <= PH_A;
                  rw          <= rx_byte[0];
                  bus_address <= rx_byte[7:1];
                  busy        <= 1'b1;
                end else begin
                  state <= ST_IDLE;
                end
              end
            end
          end

          // PH_A: wait 8th falling edge, then drive ACK. PH_B: release on 9th.
          ST_AACK: begin
            if (scl_fall) begin
              if (phase == PH_A) begin
                sda_t         <= 1'b0;
                phase         <= PH_B;
                bus_addressed <= 1'b1;
              end else begin
                sda_t   <= 1'b1;
                phase   <= PH_A;
                bit_cnt <= 4'd0;
                state   <= rw ? ST_READ : ST_WRITE;
              end
            end
          end

          ST_WRITE: begin
            if (scl_rise) begin
              rx_shift <= rx_byte;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= ST_WACK;
                phase <= PH_A;
                if (m_free) begin
                  m_axis_data_tdata  <= rx_byte;
                  m_axis_data_tvalid <= 1'b1;
                  m_axis_data_tlast  <= 1'b0;
                  pend               <= 1'b0;
                end else begin
                  pend <= 1'b1;
                end
              end
            end
          end

          // PH_A: before 8th fall. PH_STRETCH: SCL held until the sink drains.
          // PH_B: ACK driven, release on the 9th falling edge.
          ST_WACK: begin
            case (phase)
              PH_A: begin
                if (pend && m_free) begin
                  m_axis_data_tdata  <= rx_shift;
                  m_axis_data_tvalid <= 1'b1;
                  m_axis_data_tlast  <= 1'b0;
                  pend               <= 1'b0;
                end
                if (scl_fall) begin
                  sda_t <= 1'b0;
                  if (pend && !m_free) begin
                    scl_t <= 1'b0;
                    phase <= PH_STRETCH;
                  end else begin
                    phase <= PH_B;
                  end
                end
              end
              PH_STRETCH: begin
                if (m_free) begin
                  m_axis_data_tdata  <= rx_shift;
                  m_axis_data_tvalid <= 1'b1;
                  m_axis_data_tlast  <= 1'b0;
                  pend               <= 1'b0;
                  scl_t              <= 1'b1;
                  phase              <= PH_B;
                end
              end
              default: begin
                if (scl_fall) begin
                  sda_t   <= 1'b1;
                  bit_cnt <= 4'd0;
                  phase   <= PH_A;
                  state   <= ST_WRITE;
                end
              end
            endcase
          end

          // PH_A: SCL is low at a byte start; hold it until a byte arrives.
          // PH_B: shift bits out, one per falling edge.
          ST_READ: begin
            if (phase == PH_A) begin
              if (s_axis_data_tvalid) begin
                tx_shift <= {s_axis_data_tdata[6:0], 1'b0};
                sda_t    <= s_axis_data_tdata[7];
                scl_t    <= 1'b1;
                bit_cnt  <= 4'd0;
                phase    <= PH_B;
              end else begin
                scl_t <= 1'b0;
              end
            end else begin
              if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
              if (scl_fall) begin
                if (bit_cnt == 4'd8) begin
                  sda_t <= 1'b1;
                  phase <= PH_A;
                  state <= ST_RACK;
                end else begin
                  sda_t    <= tx_shift[7];
                  tx_shift <= {tx_shift[6:0], 1'b0};
                end
              end
            end
          end

          // PH_A: sample master ACK on 9th rise. PH_B: wait 9th fall.
          ST_RACK: begin
            if (phase == PH_A) begin
              if (scl_rise) begin
                if (sda_f) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end else begin
                  phase <= PH_B;
                end
              end
            end else if (scl_fall) begin
              phase <= PH_A;
              state <= ST_READ;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave
// Purpose  : Self-checking bench for i2c_slave. A behavioural I2C master
//            drives the bus; stream bytes are checked against queues of
//            expected values filled when stimulus is issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       release_bus = 1'b0;
  logic [7:0] s_tdata = 8'd0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       busy, bus_addressed, bus_active;
  logic [6:0] bus_address;
  logic       enable = 1'b1;
  logic [6:0] dev_addr = 7'h50;
  logic [6:0] dev_mask = 7'h7F;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_i, sda_i;

  assign scl_i = m_scl & scl_t;
  assign sda_i = m_sda & sda_t;

  always #5 clk = ~clk;

  i2c_slave #(.FILTER_LEN(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .release_bus         (release_bus),
    .s_axis_data_tdata   (s_tdata),
    .s_axis_data_tvalid  (s_tvalid),
    .s_axis_data_tready  (s_tready),
    .s_axis_data_tlast   (1'b0),
    .m_axis_data_tdata   (m_tdata),
    .m_axis_data_tvalid  (m_tvalid),
    .m_axis_data_tready  (m_tready),
    .m_axis_data_tlast   (m_tlast),
    .scl_i               (scl_i),
    .scl_o               (scl_o),
    .scl_t               (scl_t),
    .sda_i               (sda_i),
    .sda_o               (sda_o),
    .sda_t               (sda_t),
    .busy                (busy),
    .bus_address         (bus_address),
    .bus_addressed       (bus_addressed),
    .bus_active          (bus_active),
    .enable              (enable),
    .device_address      (dev_addr),
    .device_address_mask (dev_mask)
  );

  int         tests = 0;
  int         fails = 0;
  int         tready_cnt = 0;
  logic [8:0] m_exp[$];   // {tlast, tdata} expected on m_axis
  logic [7:0] rd_exp[$];  // bytes the master expects to read
  logic [7:0] src_q[$];   // bytes offered on s_axis
  logic [8:0] m_got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // m_axis scoreboard: a handshake is seen at the negedge before it happens.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (m_exp.size() == 0) begin
        check("m_axis_extra_byte", 32'(m_tvalid), 32'd0);
      end else begin
        m_got = m_exp.pop_front();
        check("m_axis_tdata", 32'(m_tdata), 32'(m_got[7:0]));
        check("m_axis_tlast", 32'(m_tlast), 32'(m_got[8]));
      end
    end
  end

  // s_axis source: pop on handshake, present the next byte after the edge.
  always @(negedge clk) begin
    if (!rst && s_tready) begin
      tready_cnt++;
      if (s_tvalid && src_q.size() != 0) src_q.delete(0);
    end
  end

  always @(posedge clk) begin
    #1;
    s_tvalid = (src_q.size() != 0);
    s_tdata  = (src_q.size() != 0) ? src_q[0] : 8'd0;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hw();
    cyc(HALF);
  endtask

  // Release SCL and honour clock stretching, with a bounded wait.
  task automatic scl_up();
    m_scl = 1'b1;
    for (int i = 0; i < 5000 && scl_i !== 1'b1; i++) cyc(1);
    if (scl_i !== 1'b1) check("scl_release_timeout", 32'(scl_i), 32'd1);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    hw();
    scl_up();
    hw();
    m_scl = 1'b0;
    cyc(4);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1;
    hw();
    scl_up();
    cyc(HALF / 2);
    b = sda_i;
    cyc(HALF / 2);
    m_scl = 1'b0;
    cyc(4);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    cyc(4);
    scl_up();
    hw();
    m_sda = 1'b0;
    hw();
    m_scl = 1'b0;
    cyc(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    hw();
    scl_up();
    hw();
    m_sda = 1'b1;
    hw();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic bit_v;
    b = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      b = {b[6:0], bit_v};
    end
    send_bit(nack);
  endtask

  logic       ack, ack2;
  logic [7:0] rb;

  initial begin
    // ---------------- reset state
    cyc(5);
    check("rst_scl_t", 32'(scl_t), 32'd1);
    check("rst_sda_t", 32'(sda_t), 32'd1);
    check("rst_scl_o", 32'(scl_o), 32'd1);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_outputs", 32'({s_tready, m_tvalid, m_tlast, m_tdata, busy,
                              bus_address, bus_addressed, bus_active}), 32'd0);
    rst = 1'b0;
    cyc(20);

    // ---------------- write 0x11, 0x22 to 0x50
    m_exp.push_back({1'b0, 8'h11});
    m_exp.push_back({1'b1, 8'h22});
    i2c_start();
    check("start_bus_active", 32'(bus_active), 32'd1);
    write_byte(8'hA0, ack);
    check("w_addr_ack", 32'(ack), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    check("w_bus_addressed", 32'(bus_addressed), 32'd1);
    write_byte(8'h11, ack);
    check("w_data1_ack", 32'(ack), 32'd0);
    m_tready = 1'b0;  // keep the final byte pending so STOP marks it last
    write_byte(8'h22, ack);
    check("w_data2_ack", 32'(ack), 32'd0);
    i2c_stop();
    cyc(10);
    check("w_bus_address", 32'(bus_address), 32'h50);
    check("w_busy_after_stop", 32'(busy), 32'd0);
    check("w_active_after_stop", 32'(bus_active), 32'd0);
    check("w_pending_tlast", 32'({m_tvalid, m_tlast}), 32'd3);
    m_tready = 1'b1;
    cyc(5);
    check("w_all_delivered", 32'(m_exp.size()), 32'd0);

    // ---------------- read 0xA5, 0x3C from 0x50
    tready_cnt = 0;
    src_q.push_back(8'hA5); rd_exp.push_back(8'hA5);
    src_q.push_back(8'h3C); rd_exp.push_back(8'h3C);
    i2c_start();
    write_byte(8'hA1, ack);
    check("r_addr_ack", 32'(ack), 32'd0);
    read_byte(rb, 1'b0);
    check("r_byte1", 32'(rb), 32'(rd_exp.pop_front()));
    read_byte(rb, 1'b1);
    check("r_byte2", 32'(rb), 32'(rd_exp.pop_front()));
    cyc(20);
    check("r_lines_released", 32'({scl_t, sda_t}), 32'd3);
    check("r_tready_pulses", 32'(tready_cnt), 32'd2);
    i2c_stop();
    cyc(10);

    // ---------------- address mismatch, then masked match
    tready_cnt = 0;
    i2c_start();
    write_byte(8'hA2, ack);
    check("mis_nack", 32'(ack), 32'd1);
    cyc(20);
    check("mis_bus_active", 32'(bus_active), 32'd1);
    check("mis_no_stream", 32'({busy, m_tvalid, 31'(tready_cnt)}), 32'd0);
    i2c_stop();
    cyc(10);
    check("mis_inactive_after_stop", 32'(bus_active), 32'd0);
    dev_mask = 7'h7E;
    i2c_start();
    write_byte(8'hA2, ack);
    check("mask_ack", 32'(ack), 32'd0);
    check("mask_bus_address", 32'(bus_address), 32'h51);
    i2c_stop();
    dev_mask = 7'h7F;
    cyc(10);

    // ---------------- write with a stalled sink -> SCL stretch
    m_exp.push_back({1'b0, 8'h33});
    m_exp.push_back({1'b0, 8'h44});
    m_tready = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack);
    fork
      begin
        write_byte(8'h33, ack);
        write_byte(8'h44, ack2);
      end
      begin
        for (int i = 0; i < 20000 && scl_t !== 1'b0; i++) cyc(1);
        check("st_stretch_begin", 32'(scl_t), 32'd0);
        cyc(200);
        check("st_stretch_hold", 32'(scl_t), 32'd0);
        check("st_first_byte_held", 32'({m_tvalid, m_tdata}), 32'h133);
        m_tready = 1'b1;
        cyc(1);
        check("st_stretch_release", 32'(scl_t), 32'd1);
      end
    join
    check("st_acks", 32'({ack, ack2}), 32'd0);
    i2c_stop();
    cyc(10);
    check("st_all_delivered", 32'(m_exp.size()), 32'd0);

    // ---------------- read with empty source -> SCL stretch
    i2c_start();
    write_byte(8'hA1, ack);
    fork
      read_byte(rb, 1'b1);
      begin
        cyc(100);
        check("rs_stretch_hold", 32'(scl_t), 32'd0);
        src_q.push_back(8'h80);
        rd_exp.push_back(8'h80);
        for (int i = 0; i < 10 && s_tvalid !== 1'b1; i++) begin
          @(posedge clk);
          #2;
        end
        @(posedge clk);
        #2;
        check("rs_stretch_release", 32'(scl_t), 32'd1);
      end
    join
    check("rs_byte", 32'(rb), 32'(rd_exp.pop_front()));
    i2c_stop();
    cyc(10);

    // ---------------- reset midway through a read byte
    src_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA1, ack);
    recv_bit(ack);
    recv_bit(ack);
    cyc(20);
    check("ab_sda_driven", 32'(sda_t), 32'd0);
    rst = 1'b1;
    cyc(1);
    check("ab_rst_lines", 32'({scl_t, sda_t}), 32'd3);
    check("ab_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_sda = 1'b1;
    cyc(10);
    m_scl = 1'b1;
    cyc(40);

    // ---------------- release_bus midway through a read byte
    src_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 5; i++) recv_bit(ack);
    cyc(20);
    check("rb_sda_driven", 32'({busy, sda_t}), 32'd2);
    release_bus = 1'b1;
    cyc(1);
    release_bus = 1'b0;
    check("rb_lines", 32'({scl_t, sda_t}), 32'd3);
    check("rb_busy", 32'(busy), 32'd0);
    m_sda = 1'b1;
    cyc(10);
    m_scl = 1'b1;
    cyc(40);

    // ---------------- normal write after the aborts
    m_exp.push_back({1'b0, 8'h77});
    i2c_start();
    write_byte(8'hA0, ack);
    check("post_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h77, ack);
    check("post_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    cyc(10);
    check("post_delivered", 32'(m_exp.size()), 32'd0);
    check("post_idle", 32'({busy, bus_active}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
